// File: rtl/cache_lookup_ctrl.sv
// Cache search initiator: turns valid/ready lookup requests into search strobes
// for the 8-way test cache, with a WAIT watchdog and saturating hit/miss statistics.
module cache_lookup_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 28,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_hit,
  output logic              resp_timeout,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              search_cache,
  output logic [ADDR_W-1:0] address,
  input  logic              hit,
  input  logic              search_done,
  input  logic [DATA_W-1:0] data,
  input  logic [TAG_W-1:0]  tag_out,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   address_r;
  logic                hit_seen_r;
  logic [7:0]          timer_r;
  logic                resp_hit_r;
  logic                resp_timeout_r;
  logic [DATA_W-1:0]   resp_data_r;
  logic [TAG_W-1:0]    resp_tag_r;
  logic [CNT_W-1:0]    hit_count_r;
  logic [CNT_W-1:0]    miss_count_r;

  // Handshake/strobe outputs are pure decodes of the state register.
  assign req_ready    = (state_r == ST_IDLE);
  assign busy         = (state_r != ST_IDLE);
  assign search_cache = (state_r == ST_ISSUE);
  assign resp_valid   = (state_r == ST_RESP);
  assign address      = address_r;
  assign resp_hit     = resp_hit_r;
  assign resp_timeout = resp_timeout_r;
  assign resp_data    = resp_data_r;
  assign resp_tag     = resp_tag_r;
  assign hit_count    = hit_count_r;
  assign miss_count   = miss_count_r;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; search_done wins over a coincident watchdog expiry.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) state_s = ST_ISSUE;
        else           state_s = ST_IDLE;
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (search_done)                state_s = ST_RESP;
        else if (timer_r == TMO_LAST)   state_s = ST_RESP;
        else                            state_s = ST_WAIT;
      end
      ST_RESP: begin
        if (resp_ready) state_s = ST_IDLE;
        else            state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath: address capture, sticky hit, watchdog, response fields, statistics.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      address_r      <= {ADDR_W{1'b0}};
      hit_seen_r     <= 1'b0;
      timer_r        <= 8'd0;
      resp_hit_r     <= 1'b0;
      resp_timeout_r <= 1'b0;
      resp_data_r    <= {DATA_W{1'b0}};
      resp_tag_r     <= {TAG_W{1'b0}};
      hit_count_r    <= {CNT_W{1'b0}};
      miss_count_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            address_r  <= req_addr;
            hit_seen_r <= 1'b0;
          end
        end
        ST_ISSUE: timer_r <= 8'd0;
        ST_WAIT: begin
          // The cache drops hit as search_done rises, so remember it.
          if (hit) hit_seen_r <= 1'b1;
          if (search_done) begin
            resp_hit_r     <= hit_seen_r | hit;
            resp_data_r    <= data;
            resp_tag_r     <= tag_out;
            resp_timeout_r <= 1'b0;
          end else if (timer_r == TMO_LAST) begin
            resp_timeout_r <= 1'b1;
            resp_hit_r     <= 1'b0;
            resp_data_r    <= {DATA_W{1'b0}};
            resp_tag_r     <= {TAG_W{1'b0}};
          end else begin
            timer_r <= timer_r + 8'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            if (resp_hit_r && (hit_count_r != CNT_MAX))
              hit_count_r <= hit_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (!resp_hit_r && !resp_timeout_r && (miss_count_r != CNT_MAX))
              miss_count_r <= miss_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Scoreboard bench for cache_lookup_ctrl: a scripted cache model answers each search,
// expected responses are queued at issue and checked by an independent monitor.
module tb_cache_lookup_ctrl;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int TW = 28;

  typedef struct {
    logic          hit;
    logic          tmo;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            lat;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          resp_ready = 1'b1;
  logic          hit = 1'b0;
  logic          search_done = 1'b0;
  logic [DW-1:0] data = '0;
  logic [TW-1:0] tag_out = '0;

  logic          req_ready, resp_valid, resp_hit, resp_timeout, search_cache, busy;
  logic [DW-1:0] resp_data;
  logic [TW-1:0] resp_tag;
  logic [AW-1:0] address;
  logic [15:0]   hit_count, miss_count;

  logic          s_req_ready, s_resp_valid, s_resp_hit, s_resp_timeout, s_search_cache, s_busy;
  logic [DW-1:0] s_resp_data;
  logic [TW-1:0] s_resp_tag;
  logic [AW-1:0] s_address;
  logic [3:0]    s_hit_count, s_miss_count;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            t_acc = 0;
  int            lat_meas = 0;
  int            n_issued = 0;
  int            sc_cycles = 0;
  int            hexp = 0;
  int            mexp = 0;
  int            mode = 0;          // 0 hit, 1 miss, 2 silent, 3 stray hit/done spam
  logic [DW-1:0] cache_data = '0;
  logic [TW-1:0] cache_tag = '0;

  cache_lookup_ctrl dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_timeout(resp_timeout), .resp_data(resp_data),
    .resp_tag(resp_tag), .search_cache(search_cache), .address(address), .hit(hit),
    .search_done(search_done), .data(data), .tag_out(tag_out),
    .hit_count(hit_count), .miss_count(miss_count), .busy(busy)
  );

  cache_lookup_ctrl #(.CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_addr(req_addr), .resp_valid(s_resp_valid), .resp_ready(resp_ready),
    .resp_hit(s_resp_hit), .resp_timeout(s_resp_timeout), .resp_data(s_resp_data),
    .resp_tag(s_resp_tag), .search_cache(s_search_cache), .address(s_address), .hit(hit),
    .search_done(search_done), .data(data), .tag_out(tag_out),
    .hit_count(s_hit_count), .miss_count(s_miss_count), .busy(s_busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Cache model: hit three negedges after the ISSUE cycle, search_done on the next.
  initial begin
    int m;
    forever begin
      @(negedge clock);
      if (mode == 3) begin
        hit = 1'b1;
        search_done = 1'b1;
      end else begin
        hit = 1'b0;
        search_done = 1'b0;
        m = mode;
        if (search_cache && m != 2) begin
          repeat (3) @(negedge clock);
          hit = (m == 0);
          data = cache_data;
          tag_out = cache_tag;
          @(negedge clock);
          hit = 1'b0;
          search_done = 1'b1;
        end
      end
    end
  end

  // Strobe width monitor: one search_cache cycle per issued request.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (search_cache) sc_cycles++;
    end
  end

  // Response monitor: latency on the rising edge of resp_valid, fields at handshake.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (resp_valid && !prev_v) lat_meas = cyc - t_acc;
      prev_v = resp_valid;
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_resp", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          chk("resp_hit", 64'(resp_hit), 64'(e.hit));
          chk("resp_timeout", 64'(resp_timeout), 64'(e.tmo));
          chk("resp_data", 64'(resp_data), 64'(e.data));
          chk("resp_tag", 64'(resp_tag), 64'(e.tag));
          chk("latency", 64'(lat_meas), 64'(e.lat));
        end
      end
    end
  end

  task automatic check_counts();
    chk("hit_count", 64'(hit_count), 64'(hexp));
    chk("miss_count", 64'(miss_count), 64'(mexp));
    chk("sat_hit_count", 64'(s_hit_count), 64'((hexp > 15) ? 15 : hexp));
    chk("sat_miss_count", 64'(s_miss_count), 64'((mexp > 15) ? 15 : mexp));
  endtask

  task automatic issue(input logic [AW-1:0] a, input int m, input logic [DW-1:0] d,
                       input logic [TW-1:0] t, input int lat, input bit push);
    int k;
    exp_t e;
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'(1));
    mode = m;
    cache_data = d;
    cache_tag = t;
    req_addr = a;
    req_valid = 1'b1;
    e.hit  = (m == 0);
    e.tmo  = (m == 2);
    e.data = (m == 2) ? '0 : d;
    e.tag  = (m == 2) ? '0 : t;
    e.lat  = lat;
    if (push) q.push_back(e);
    @(negedge clock);
    req_valid = 1'b0;
    t_acc = cyc;
    n_issued++;
    chk("address", 64'(address), 64'(a));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("idle_reached", 64'(busy), 64'(0));
    chk("sb_drained", 64'(q.size()), 64'(0));
    chk("search_pulses", 64'(sc_cycles), 64'(n_issued));
  endtask

  task automatic run(input logic [AW-1:0] a, input int m, input logic [DW-1:0] d,
                     input logic [TW-1:0] t, input int lat);
    issue(a, m, d, t, lat, 1'b1);
    wait_idle();
    if (m == 0) hexp++;
    if (m == 1) mexp++;
    check_counts();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_search_cache", 64'(search_cache), 64'(0));
    chk("rst_address", 64'(address), 64'(0));
    check_counts();
    reset = 1'b1;
    @(negedge clock);

    // Hit, miss and watchdog timeout (15 WAIT cycles -> 16 cycles to resp_valid).
    run(32'h0000_0005, 0, 64'h19, 28'h5, 5);
    run(32'h1234_0000, 1, 64'h0123_4567_89ab_cdef, 28'hcafe123, 5);
    run(32'hdead_0000, 2, 64'h1111, 28'h22, 16);

    // Stray hit/search_done in IDLE must not start anything or count.
    mode = 3;
    repeat (3) @(negedge clock);
    chk("stray_busy", 64'(busy), 64'(0));
    chk("stray_resp_valid", 64'(resp_valid), 64'(0));
    mode = 0;
    repeat (2) @(negedge clock);
    check_counts();

    // Backpressure: response held 10 cycles while a new request waits.
    resp_ready = 1'b0;
    issue(32'h0000_00a0, 0, 64'hbeef, 28'hab, 5, 1'b1);
    k = 0;
    while (!resp_valid && k < 50) begin
      @(negedge clock);
      k++;
    end
    req_addr = 32'h0000_0077;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bp_resp_valid", 64'(resp_valid), 64'(1));
      chk("bp_resp_hit", 64'(resp_hit), 64'(1));
      chk("bp_resp_data", 64'(resp_data), 64'h0000_0000_0000_beef);
      chk("bp_resp_tag", 64'(resp_tag), 64'(28'hab));
      chk("bp_req_ready", 64'(req_ready), 64'(0));
      chk("bp_address", 64'(address), 64'(32'h0000_00a0));
    end
    begin
      exp_t e;
      e.hit = 1'b1; e.tmo = 1'b0; e.data = 64'h33; e.tag = 28'h3; e.lat = 5;
      q.push_back(e);
    end
    cache_data = 64'h33;
    cache_tag = 28'h3;
    resp_ready = 1'b1;
    @(negedge clock);
    chk("bubble_busy", 64'(busy), 64'(0));
    chk("bubble_req_ready", 64'(req_ready), 64'(1));
    @(negedge clock);
    req_valid = 1'b0;
    t_acc = cyc;
    n_issued++;
    chk("bp_accept_busy", 64'(busy), 64'(1));
    chk("bp_accept_address", 64'(address), 64'(32'h0000_0077));
    wait_idle();
    hexp += 2;
    check_counts();

    // Asynchronous reset during WAIT aborts the lookup with no response.
    issue(32'h0000_0abc, 2, 64'h0, 28'h0, 0, 1'b0);
    repeat (3) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    hexp = 0;
    mexp = 0;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("mid_rst_search_cache", 64'(search_cache), 64'(0));
    chk("mid_rst_address", 64'(address), 64'(0));
    chk("mid_rst_resp_timeout", 64'(resp_timeout), 64'(0));
    chk("mid_rst_resp_data", 64'(resp_data), 64'(0));
    check_counts();
    @(negedge clock);
    reset = 1'b1;
    mode = 0;
    @(negedge clock);
    run(32'h0000_0100, 0, 64'h5a5a, 28'h1a, 5);

    // Saturation: the 4-bit instance pins at 0xF.
    for (int i = 0; i < 17; i++) begin
      run(32'h0000_1000 + 32'(i), 0, 64'(i + 1), 28'(i + 2), 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
